// File: rtl/uart_pkg.sv
// Shared UART constants and the byte type used between receiver and buffer.
package uart_pkg;
   localparam int UART_DATA_W        = 8;
   localparam int UART_RX_FIFO_DEPTH = 16;
   typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA storage: one synchronous write port, one asynchronous read port.
// No reset on the array; the owner gates the read data with its own valid flag.
module fifo_mem #(
   parameter int  DATA   = 8,
   parameter int  DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_divided_clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_idx,
   input  logic [DATA-1:0]   i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_idx,
   output logic [DATA-1:0]   o_rd_data
);
   logic [DATA-1:0] mem [DEPTH];

   always_ff @(posedge i_divided_clk) begin
      if (i_wr_en) mem[i_wr_idx] <= i_wr_data;
   end

   assign o_rd_data = mem[i_rd_idx];
endmodule

// File: rtl/uart_rx_fifo.sv
// UART RX byte buffer: captures on ready rising edge, FWFT head one cycle after the edge; no
// backpressure to the receiver, a byte arriving while full is dropped and sets sticky overflow. Optional: UART_RX_FIFO_COUNT_EN.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int  DATA   = UART_DATA_W,
   parameter int  DEPTH  = UART_RX_FIFO_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic            i_divided_clk,
   input  logic            i_rst,
   input  logic            i_en,
   input  logic [DATA-1:0] i_rx_data,
   input  logic            i_rx_ready,
   input  logic            i_pop,
   input  logic            i_clr_overflow,
   output logic [DATA-1:0] o_data,
   output logic            o_valid,
   output logic            o_full,
`ifdef UART_RX_FIFO_COUNT_EN
   output logic [ADDR_W:0] o_count,
   output logic            o_half,
`endif
   output logic            o_overflow
);
   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

   logic [ADDR_W:0] wr_ptr, rd_ptr;
   logic            ready_q;
   logic            overflow_q;
   logic            empty, full;
   logic            push_req, pop_ok, push_ok;
   logic [DATA-1:0] head_data;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
   assign push_req = i_rx_ready & ~ready_q & i_en;
   assign pop_ok   = i_pop & ~empty;
   assign push_ok  = push_req & (~full | pop_ok);

   always_ff @(posedge i_divided_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ready_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         ready_q <= i_rx_ready;
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push_req & full & ~pop_ok) overflow_q <= 1'b1;
         else if (i_clr_overflow)       overflow_q <= 1'b0;
      end
   end

   fifo_mem #(.DATA(DATA), .DEPTH(DEPTH)) u_mem (
      .i_divided_clk (i_divided_clk),
      .i_wr_en       (push_ok),
      .i_wr_idx      (wr_ptr[ADDR_W-1:0]),
      .i_wr_data     (i_rx_data),
      .i_rd_idx      (rd_ptr[ADDR_W-1:0]),
      .o_rd_data     (head_data)
   );

   // Stale or uninitialised entries never leak out while empty.
   assign o_data     = empty ? '0 : head_data;
   assign o_valid    = ~empty;
   assign o_full     = full;
   assign o_overflow = overflow_q;

`ifdef UART_RX_FIFO_COUNT_EN
   logic [ADDR_W:0] count_q;

   always_ff @(posedge i_divided_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= '0;
      end else if (push_ok & ~pop_ok) begin
         count_q <= count_q + PTR_ONE;
      end else if (pop_ok & ~push_ok) begin
         count_q <= count_q - PTR_ONE;
      end
   end

   assign o_count = count_q;
   assign o_half  = (count_q >= (ADDR_W+1)'(DEPTH/2));
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: inputs driven and outputs sampled on the falling edge.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst, en, rx_ready, pop, clr;
   uart_byte_t rx_data;
   uart_byte_t data;
   logic       valid, full, overflow;
`ifdef UART_RX_FIFO_COUNT_EN
   logic [4:0] count;
   logic       half;
`endif

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_rx_fifo dut (
      .i_divided_clk  (clk),
      .i_rst          (rst),
      .i_en           (en),
      .i_rx_data      (rx_data),
      .i_rx_ready     (rx_ready),
      .i_pop          (pop),
      .i_clr_overflow (clr),
      .o_data         (data),
      .o_valid        (valid),
      .o_full         (full),
`ifdef UART_RX_FIFO_COUNT_EN
      .o_count        (count),
      .o_half         (half),
`endif
      .o_overflow     (overflow)
   );

   task automatic chk1(input string tag, input logic obs, input logic expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: got %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: got %02h expected %02h", tag, obs, expv);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic pop_one();
      @(negedge clk);
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
   endtask

   initial begin
      rst = 1'b0; en = 1'b1; rx_data = '0; rx_ready = 1'b1; pop = 1'b0; clr = 1'b0;

      // Asynchronous reset, before any clock edge; ready already high.
      #2 rst = 1'b1;
      #1;
      chk1("rst_valid", valid, 1'b0);
      chk1("rst_full", full, 1'b0);
      chk1("rst_overflow", overflow, 1'b0);
      chk8("rst_data", data, 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk1("stale_ready_no_push", valid, 1'b0);
      rx_ready = 1'b0;

      // Single byte, one-cycle latency, then pop.
      push_byte(8'hA5);
      chk1("single_valid", valid, 1'b1);
      chk8("single_data", data, 8'hA5);
      pop_one();
      chk1("single_popped", valid, 1'b0);

      // Ready held high for 20 cycles gives exactly one push.
      @(negedge clk);
      rx_data = 8'h3C; rx_ready = 1'b1;
      repeat (20) @(negedge clk);
      rx_ready = 1'b0;
      chk8("held_data", data, 8'h3C);
      pop_one();
      chk1("held_one_push", valid, 1'b0);

      // Capture disabled.
      en = 1'b0;
      push_byte(8'h77);
      chk1("en_low_no_push", valid, 1'b0);
      en = 1'b1;

      // Fill 00..0F.
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      chk1("fill_full", full, 1'b1);
      chk8("fill_head", data, 8'h00);
`ifdef UART_RX_FIFO_COUNT_EN
      chk8("fill_count", 8'(count), 8'd16);
      chk1("fill_half", half, 1'b1);
`endif
      for (int i = 0; i < 4; i++) begin
         chk8("pop_early", data, 8'(i));
         pop_one();
      end
      chk1("after_pop4_not_full", full, 1'b0);
      for (int i = 16; i < 20; i++) push_byte(8'(i));
      chk1("wrap_full", full, 1'b1);

      // Overflow: byte dropped, flag sticky, set beats clear.
      push_byte(8'hEE);
      chk1("ovf_set", overflow, 1'b1);
      chk1("ovf_still_full", full, 1'b1);
      chk8("ovf_head_unchanged", data, 8'h04);
      @(negedge clk);
      rx_data = 8'hEF; rx_ready = 1'b1; clr = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0; clr = 1'b0;
      chk1("ovf_set_wins", overflow, 1'b1);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk1("ovf_cleared", overflow, 1'b0);

      // Push and pop together while full: both accepted, no overflow.
      @(negedge clk);
      rx_data = 8'h55; rx_ready = 1'b1; pop = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0; pop = 1'b0;
      chk1("simul_full_stays", full, 1'b1);
      chk1("simul_no_ovf", overflow, 1'b0);
      for (int i = 5; i < 20; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'h55);
      for (int i = 0; i < 16; i++) begin
         chk8("drain_order", data, exp_q[i]);
         pop_one();
      end
      chk1("drain_empty", valid, 1'b0);
      chk1("drain_not_full", full, 1'b0);

      // Push and pop together while empty: pop ignored, byte kept.
      @(negedge clk);
      rx_data = 8'h9A; rx_ready = 1'b1; pop = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0; pop = 1'b0;
      chk1("simul_empty_valid", valid, 1'b1);
      chk8("simul_empty_data", data, 8'h9A);
      pop_one();
      chk1("simul_empty_popped", valid, 1'b0);

      // Reset mid-operation with ready left high.
      push_byte(8'h11);
      push_byte(8'h22);
      @(negedge clk);
      rx_data = 8'h33; rx_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk1("midrst_valid", valid, 1'b0);
      chk8("midrst_data", data, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk1("midrst_no_recapture", valid, 1'b0);
      rx_ready = 1'b0;
      push_byte(8'h44);
      chk8("post_rst_push", data, 8'h44);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
